hb_iq_stream_fifo: RTL and testbench
====================================

Name: hb_iq_stream_fifo

Overview:
Downstream neighbour of the half-band decimation cascade.
- Accepts decimated I/Q samples from the final half-band stage (valid-only, no backpressure) and packs each pair into one {Q,I} word.
- Buffers the words in a first-word-fall-through FIFO and presents them on a ready/valid stream to the packet/DMA logic.
- Absorbs consumer stalls; drops and counts samples on overflow, because the decimator cannot be stalled.

Parameters:
WIDTH, 16, bit width of each I and Q sample.
DEPTH, 16, FIFO depth in packed words; power of two, minimum 4.
AFULL_LEVEL, 12, occupancy at or above which o_almost_full asserts; must be less than DEPTH.

Ports:
i_clock  input  1  single clock for all logic.
i_reset  input  1  synchronous reset, active-low (sampled on rising i_clock; 0 = reset).
i_inph_data  input  WIDTH  decimated in-phase sample.
i_quad_data  input  WIDTH  decimated quadrature sample.
i_valid  input  1  input sample pair present this cycle.
o_data  output  2*WIDTH  packed head word: [2*WIDTH-1:WIDTH] = Q, [WIDTH-1:0] = I.
o_valid  output  1  o_data holds a valid word.
i_ready  input  1  consumer accepts o_data this cycle.
o_level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
o_almost_full  output  1  o_level >= AFULL_LEVEL.
o_overflow  output  1  sticky flag; at least one sample has been dropped.
o_drop_count  output  16  number of dropped samples, saturating at 0xFFFF.
i_clear_overflow  input  1  synchronous clear of o_overflow and o_drop_count.

Behaviour:
- Reset (i_reset == 0 at a clock edge):
  - Pointers and level go to 0; o_valid = 0; o_data = 0; o_overflow = 0; o_drop_count = 0; o_almost_full = 0.
  - FIFO contents are discarded.
  - Reset takes priority over every other input, including mid-transfer; a word presented but not yet popped is lost.
- Pop: occurs when o_valid && i_ready at a clock edge. Read pointer advances modulo DEPTH.
- Push: occurs when i_valid && (level < DEPTH || pop in the same cycle). Writes {i_quad_data, i_inph_data} at the write pointer, which advances modulo DEPTH.
- Simultaneous push and pop: level unchanged. This holds when full: the slot freed by the pop is reused and no drop occurs.
- Drop: i_valid && level == DEPTH && no pop.
  - Sample discarded; o_overflow set to 1.
  - o_drop_count increments by 1, holding at 0xFFFF once reached.
  - FIFO contents are untouched.
- i_clear_overflow: on the next edge, o_overflow = 0 and o_drop_count = 0. If a drop happens in the same cycle, the drop wins: o_overflow = 1, o_drop_count = 1.
- o_valid / o_data:
  - o_valid = (level != 0). The FWFT head word is visible combinationally from registered storage.
  - Latency: a word pushed into an empty FIFO at edge N shows o_valid = 1 and that word after edge N, so it can be popped at edge N+1.
  - o_data is forced to 0 whenever o_valid = 0.
  - o_data is stable while o_valid && !i_ready.
- i_ready while o_valid = 0 has no effect; level never underflows.
- o_level and o_almost_full are registered and reflect the post-edge occupancy.
- Packing is bit-exact with no arithmetic; WIDTH bits pass through unchanged.
- Pointer wrap: pointers are $clog2(DEPTH)+1 bits; full/empty are resolved via the extra MSB and are consistent with o_level.

Test Plan:
- Reset hold: i_reset = 0 for 3 cycles with i_valid = 1, I=0x1234, Q=0x5678 -> o_valid = 0, o_data = 0, o_level = 0, o_overflow = 0 throughout.
- Single pass: push I=0x0001, Q=0xFFFF with i_ready = 1 -> o_valid = 1 one cycle later, o_data = 0xFFFF0001, popped at the next edge, o_level returns to 0.
- Fill and stall: i_ready = 0, push 16 words I=k, Q=0x100+k (k=0..15) -> o_level = 16, o_almost_full = 1 from level 12; o_overflow = 0; then i_ready = 1 -> 16 words drain in order with no bubbles.
- Overflow: with FIFO full and i_ready = 0, push 3 more words -> o_overflow = 1, o_drop_count = 3, contents unchanged; assert i_clear_overflow -> both cleared next cycle.
- Full with simultaneous push/pop: FIFO full, i_valid = 1 and i_ready = 1 for 20 cycles -> no drops, o_level stays 16, output order preserved across the pointer wrap.
- Reset mid-operation: FIFO holding 5 words, i_reset = 0 for 1 cycle -> o_level = 0, o_valid = 0, o_drop_count = 0; the next push appears normally.

Source files
------------

// File: rtl/hb_iq_stream_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : hb_iq_stream_fifo
//  Brief    : Packs decimated I/Q pairs into {Q,I} words and buffers them in a
//             first-word-fall-through FIFO feeding a ready/valid consumer.
//             Overflowing samples are dropped and counted, because the
//             upstream decimator cannot be stalled.
//  Revision : 1.0 - initial release
// ============================================================================
module hb_iq_stream_fifo #(
  parameter int WIDTH       = 16,
  parameter int DEPTH       = 16,
  parameter int AFULL_LEVEL = 12
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic [WIDTH-1:0]           i_inph_data,
  input  logic [WIDTH-1:0]           i_quad_data,
  input  logic                       i_valid,
  output logic [2*WIDTH-1:0]         o_data,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [$clog2(DEPTH):0]     o_level,
  output logic                       o_almost_full,
  output logic                       o_overflow,
  output logic [15:0]                o_drop_count,
  input  logic                       i_clear_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] c_AFULL_LVL = LW'(AFULL_LEVEL);
  localparam logic [15:0]   c_DROP_MAX  = 16'hFFFF;

  // Storage and state
  logic [2*WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]        wr_ptr_q, wr_ptr_d;
  logic [AW:0]        rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]      level_q, level_d;
  logic               afull_q;
  logic               ovf_q, ovf_d;
  logic [15:0]        drop_q, drop_d;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  // Full/empty from the extra pointer MSB: equal pointers mean empty, equal
  // index with differing MSB means every slot is occupied.
  assign w_empty = (wr_ptr_q == rd_ptr_q);
  assign w_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign w_pop  = !w_empty && i_ready;
  assign w_push = i_valid && (!w_full || w_pop);
  assign w_drop = i_valid && w_full && !w_pop;

  // Next-state for pointers, occupancy and the overflow bookkeeping.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    drop_d   = drop_q;

    if (w_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (w_pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    case ({w_push, w_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    // A drop in the same cycle as a clear wins and restarts the count at 1.
    if (w_drop) begin
      ovf_d = 1'b1;
      if (i_clear_overflow)         drop_d = 16'd1;
      else if (drop_q != c_DROP_MAX) drop_d = drop_q + 16'd1;
    end else if (i_clear_overflow) begin
      ovf_d  = 1'b0;
      drop_d = 16'd0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      afull_q  <= 1'b0;
      ovf_q    <= 1'b0;
      drop_q   <= 16'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      afull_q  <= (level_d >= c_AFULL_LVL);
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
    end
  end

  // Word storage; contents need no reset since o_data is masked when empty.
  always_ff @(posedge i_clock) begin
    if (i_reset && w_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {i_quad_data, i_inph_data};
    end
  end

  assign o_valid       = !w_empty;
  assign o_data        = o_valid ? mem_q[rd_ptr_q[AW-1:0]] : '0;
  assign o_level       = level_q;
  assign o_almost_full = afull_q;
  assign o_overflow    = ovf_q;
  assign o_drop_count  = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_hb_iq_stream_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hb_iq_stream_fifo
//  Brief    : Randomised plus directed bench for hb_iq_stream_fifo with a
//             queue-based reference model and a decoupled output monitor.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hb_iq_stream_fifo;

  localparam int WIDTH = 16;
  localparam int DEPTH = 16;
  localparam int AFULL = 12;

  logic        clk;
  logic        rst_n;
  logic [15:0] inph, quad;
  logic        vld, rdy, clr;
  logic [31:0] o_data;
  logic        o_valid;
  logic [4:0]  o_level;
  logic        o_almost_full;
  logic        o_overflow;
  logic [15:0] o_drop_count;

  hb_iq_stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_LEVEL(AFULL)) dut (
    .i_clock          (clk),
    .i_reset          (rst_n),
    .i_inph_data      (inph),
    .i_quad_data      (quad),
    .i_valid          (vld),
    .o_data           (o_data),
    .o_valid          (o_valid),
    .i_ready          (rdy),
    .o_level          (o_level),
    .o_almost_full    (o_almost_full),
    .o_overflow       (o_overflow),
    .o_drop_count     (o_drop_count),
    .i_clear_overflow (clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: expected FIFO contents and post-edge flags.
  logic [31:0] exp_q[$];
  int          mdl_level;
  logic        mdl_ovf;
  logic [15:0] mdl_drops;
  logic        mon_en;
  int          checks;
  int          errors;
  logic [31:0] exp_word;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Apply one edge of the specified behaviour to the model. The monitor has
  // already removed a popped head word from exp_q at the preceding negedge.
  task automatic model_edge();
    bit pop, push, drop;
    if (!rst_n) begin
      mdl_level = 0;
      exp_q.delete();
      mdl_ovf   = 1'b0;
      mdl_drops = 16'd0;
    end else begin
      pop  = (mdl_level != 0) && rdy;
      push = vld && (mdl_level < DEPTH || pop);
      drop = vld && (mdl_level == DEPTH) && !pop;
      if (push) exp_q.push_back({quad, inph});
      mdl_level = mdl_level + int'(push) - int'(pop);
      if (drop) begin
        mdl_ovf   = 1'b1;
        mdl_drops = clr ? 16'd1 : ((mdl_drops == 16'hFFFF) ? mdl_drops : mdl_drops + 16'd1);
      end else if (clr) begin
        mdl_ovf   = 1'b0;
        mdl_drops = 16'd0;
      end
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, then update the model.
  task automatic step(input logic r, input logic v, input logic [15:0] ii,
                      input logic [15:0] qq, input logic rd, input logic c);
    rst_n = r; vld = v; inph = ii; quad = qq; rdy = rd; clr = c;
    @(posedge clk);
    #1;
    model_edge();
    mon_en = 1'b1;
  endtask

  // Monitor: compares DUT outputs mid-cycle; pops the scoreboard on a handshake.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("level", 64'(o_level), 64'(mdl_level));
      chk("valid", 64'(o_valid), 64'(mdl_level != 0));
      chk("almost_full", 64'(o_almost_full), 64'(mdl_level >= AFULL));
      chk("overflow", 64'(o_overflow), 64'(mdl_ovf));
      chk("drop_count", 64'(o_drop_count), 64'(mdl_drops));
      if (mdl_level != 0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_empty actual=0 expected=%0d", mdl_level);
        end else begin
          exp_word = (rdy && rst_n) ? exp_q.pop_front() : exp_q[0];
          chk("data", 64'(o_data), 64'(exp_word));
        end
      end else begin
        chk("data_idle", 64'(o_data), 64'd0);
      end
    end
  end

  initial begin
    checks = 0; errors = 0; mon_en = 1'b0;
    mdl_level = 0; mdl_ovf = 1'b0; mdl_drops = 16'd0;
    rst_n = 1'b0; vld = 1'b0; inph = '0; quad = '0; rdy = 1'b0; clr = 1'b0;

    // Reset held with a sample offered every cycle.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'h1234, 16'h5678, 1'b1, 1'b0);

    // Single word through an empty FIFO.
    step(1'b1, 1'b1, 16'h0001, 16'hFFFF, 1'b1, 1'b0);
    step(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
    step(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);

    // Fill with the consumer stalled.
    for (int k = 0; k < 16; k++) step(1'b1, 1'b1, 16'(k), 16'(16'h100 + k), 1'b0, 1'b0);
    // Three overflowing samples, then clear.
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 16'hDEAD, 16'hBEEF, 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    // Drop coinciding with clear: drop wins with a count of one.
    step(1'b1, 1'b1, 16'hAAAA, 16'h5555, 1'b0, 1'b1);
    step(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    // Drain all sixteen back to back.
    for (int k = 0; k < 16; k++) step(1'b1, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0);

    // Refill, then push and pop together while full across the pointer wrap.
    for (int k = 0; k < 16; k++) step(1'b1, 1'b1, 16'(16'h2000 + k), 16'(16'h3000 + k), 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) step(1'b1, 1'b1, 16'(16'h4000 + k), 16'(16'h5000 + k), 1'b1, 1'b0);
    // Drain down to five words, then reset mid-operation.
    for (int k = 0; k < 11; k++) step(1'b1, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 16'hC0DE, 16'hF00D, 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0);

    // Randomised traffic with phases of differing consumer throughput.
    for (int i = 0; i < 3000; i++) begin
      int rdy_pct;
      rdy_pct = ((i / 300) % 3 == 0) ? 20 : (((i / 300) % 3 == 1) ? 60 : 95);
      step(($urandom_range(0, 199) != 0),
           ($urandom_range(0, 99) < 70),
           16'($urandom), 16'($urandom),
           ($urandom_range(0, 99) < rdy_pct),
           ($urandom_range(0, 49) == 0));
    end

    step(1'b1, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
